// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO controllers.
//   bin2gray / gray2bin : pointer code conversions. Both operate on a
//   GRAY_MAX_W-bit vector; callers zero-extend their narrower pointer on the
//   way in and truncate on the way out. Leading zeros do not disturb either
//   conversion, so one function pair serves every pointer width up to
//   GRAY_MAX_W.
// Optional build macro used by the read-side controller: FIFO_RD_USEDW_EN.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] i_gray);
    logic [GRAY_MAX_W-1:0] w_bin;
    w_bin[GRAY_MAX_W-1] = i_gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end
    return w_bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// -----------------------------------------------------------------------------
// gray_sync
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Pure flop chain: nothing sits between the stages so every stage has a full
// clock period to resolve metastability.
// Ports:
//   clk_i  : destination-domain clock
//   aclr_i : asynchronous active-high clear, forces every stage to 0
//   d_i    : WIDTH-bit Gray pointer from the source domain
//   q_o    : synchronized pointer (output of the last stage)
// Parameters: WIDTH (pointer width), STAGES (flop count, 2 or more).
// -----------------------------------------------------------------------------
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             aclr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_sync[0] <= '0;
    end else begin
      r_sync[0] <= d_i;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
          r_sync[gi] <= '0;
        end else begin
          r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the dual-clock FIFO. Owns the read pointer, RAM read
// address/strobe, empty flag and fill count, synchronizes the write pointer
// into rd_clk_i and publishes a registered Gray read pointer.
// Ports:
//   rd_clk_i       : read clock (all registers)
//   aclr_i         : asynchronous active-high reset
//   rd_req_i       : consumer read request
//   wr_pntr_gray_i : Gray write pointer from the write domain (AWIDTH+1)
//   rd_pntr_o      : RAM read address (binary read pointer without MSB)
//   ram_rd_req_o   : RAM read strobe (accepted read)
//   rd_empty_o     : empty flag (pessimistic)
//   rd_usedw_o     : words available, 0..2**AWIDTH
//   rd_pntr_gray_o : registered Gray read pointer to the write domain
//   underflow_o    : one-cycle pulse on a read request while empty
// Build option: FIFO_RD_USEDW_EN builds the fill counter; without it
// rd_usedw_o is tied to 0 and everything else is unchanged.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int AWIDTH      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rd_clk_i,
  input  logic              aclr_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic              ram_rd_req_o,
  output logic              rd_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic [AWIDTH:0]   rd_pntr_gray_o,
  output logic              underflow_o
);

  localparam int PW = AWIDTH + 1;

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_gray;
  logic          r_empty;
  logic          r_underflow;

  logic          w_rd_ack;
  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_wr_gray_s;

  // The empty flag gates acceptance, so the last word read sets empty on the
  // same edge and a following request cannot over-read.
  assign w_rd_ack       = rd_req_i & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + PW'(w_rd_ack);
  assign w_rd_gray_next = PW'(bin2gray(GRAY_MAX_W'(w_rd_bin_next)));

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i  (rd_clk_i),
    .aclr_i (aclr_i),
    .d_i    (wr_pntr_gray_i),
    .q_o    (w_wr_gray_s)
  );

  // Empty compares the next read pointer against the (stale) synchronized
  // write pointer: lag can only make it claim empty longer, never shorter.
  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_rd_bin    <= w_rd_bin_next;
      r_rd_gray   <= w_rd_gray_next;
      r_empty     <= (w_rd_gray_next == w_wr_gray_s);
      r_underflow <= rd_req_i & r_empty;
    end
  end

`ifdef FIFO_RD_USEDW_EN
  logic [PW-1:0] w_wr_bin_s;
  logic [PW-1:0] r_usedw;

  assign w_wr_bin_s = PW'(gray2bin(GRAY_MAX_W'(w_wr_gray_s)));

  // Modulo-2**PW difference; the wrap bit makes a full FIFO read as 2**AWIDTH.
  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_usedw <= '0;
    end else begin
      r_usedw <= w_wr_bin_s - w_rd_bin_next;
    end
  end

  assign rd_usedw_o = r_usedw;
`else
  assign rd_usedw_o = '0;
`endif

  assign rd_pntr_o      = r_rd_bin[AWIDTH-1:0];
  assign rd_pntr_gray_o = r_rd_gray;
  assign rd_empty_o     = r_empty;
  assign underflow_o    = r_underflow;
  assign ram_rd_req_o   = w_rd_ack;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Bench for fifo_rd_ctrl (AWIDTH=3, SYNC_STAGES=2). A reference model tracks
// the read count and a two-sample history of the written count; every falling
// edge all outputs are compared against it. Directed scenarios add literal
// expectations. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_USEDW_EN
  localparam bit USEDW = 1'b1;
`else
  localparam bit USEDW = 1'b0;
`endif

  logic       rd_clk_i = 1'b0;
  logic       aclr_i   = 1'b1;
  logic       rd_req_i = 1'b0;
  logic [3:0] wr_pntr_gray_i;
  logic [2:0] rd_pntr_o;
  logic       ram_rd_req_o;
  logic       rd_empty_o;
  logic [3:0] rd_usedw_o;
  logic [3:0] rd_pntr_gray_o;
  logic       underflow_o;

  int wr_bin = 0;
  int n_vec  = 0;
  int n_bad  = 0;

  assign wr_pntr_gray_i = 4'(wr_bin ^ (wr_bin >> 1));

  fifo_rd_ctrl #(.AWIDTH(3), .SYNC_STAGES(2)) dut (
    .rd_clk_i       (rd_clk_i),
    .aclr_i         (aclr_i),
    .rd_req_i       (rd_req_i),
    .wr_pntr_gray_i (wr_pntr_gray_i),
    .rd_pntr_o      (rd_pntr_o),
    .ram_rd_req_o   (ram_rd_req_o),
    .rd_empty_o     (rd_empty_o),
    .rd_usedw_o     (rd_usedw_o),
    .rd_pntr_gray_o (rd_pntr_gray_o),
    .underflow_o    (underflow_o)
  );

  initial forever #5 rd_clk_i = ~rd_clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_rd : words read so far (mod 16); m_h0/m_h1 : written count seen at the
  // last two edges. The written count becomes usable two edges after it is
  // sampled, and the flags are registered on the edge after that.
  int m_rd = 0, m_h0 = 0, m_h1 = 0, m_usedw = 0;
  bit m_empty = 1'b1, m_uf = 1'b0;

  function automatic int rd_next();
    return (m_rd + ((rd_req_i && !m_empty) ? 1 : 0)) % 16;
  endfunction

  always @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      m_rd <= 0; m_h0 <= 0; m_h1 <= 0;
      m_empty <= 1'b1; m_usedw <= 0; m_uf <= 1'b0;
    end else begin
      m_rd    <= rd_next();
      m_h0    <= wr_bin;
      m_h1    <= m_h0;
      m_empty <= (rd_next() == m_h1);
      m_usedw <= (m_h1 - rd_next() + 16) % 16;
      m_uf    <= rd_req_i && m_empty;
    end
  end

  always @(negedge rd_clk_i) begin
    chk("addr",      int'(rd_pntr_o),      m_rd % 8);
    chk("gray",      int'(rd_pntr_gray_o), m_rd ^ (m_rd >> 1));
    chk("empty",     int'(rd_empty_o),     int'(m_empty));
    chk("usedw",     int'(rd_usedw_o),     USEDW ? m_usedw : 0);
    chk("underflow", int'(underflow_o),    int'(m_uf));
    chk("ram_rd_req", int'(ram_rd_req_o),  (rd_req_i && !m_empty) ? 1 : 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int strobes;
  initial begin
    repeat (3) @(posedge rd_clk_i);
    #1 aclr_i = 1'b0;
    @(negedge rd_clk_i);
    chk("rst_empty", int'(rd_empty_o), 1);
    chk("rst_addr",  int'(rd_pntr_o), 0);
    chk("rst_usedw", int'(rd_usedw_o), 0);

    // write pointer crossing: visible on the 3rd edge
    @(posedge rd_clk_i); #1 wr_bin = 1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge rd_clk_i); @(negedge rd_clk_i);
      chk("cross_empty", int'(rd_empty_o), (e < 3) ? 1 : 0);
    end
    chk("cross_usedw", int'(rd_usedw_o), USEDW ? 1 : 0);

    // single read
    @(posedge rd_clk_i); #1 rd_req_i = 1'b1;
    @(negedge rd_clk_i);
    chk("rd1_strobe", int'(ram_rd_req_o), 1);
    chk("rd1_addr",   int'(rd_pntr_o), 0);
    @(posedge rd_clk_i); #1 rd_req_i = 1'b0;
    @(negedge rd_clk_i);
    chk("rd1_addr_after", int'(rd_pntr_o), 1);
    chk("rd1_gray_after", int'(rd_pntr_gray_o), 1);
    chk("rd1_empty",      int'(rd_empty_o), 1);
    chk("rd1_usedw",      int'(rd_usedw_o), 0);

    // underflow
    @(posedge rd_clk_i); #1 rd_req_i = 1'b1;
    @(negedge rd_clk_i);
    chk("uf_strobe", int'(ram_rd_req_o), 0);
    @(posedge rd_clk_i); #1 rd_req_i = 1'b0;
    @(negedge rd_clk_i);
    chk("uf_pulse", int'(underflow_o), 1);
    chk("uf_addr",  int'(rd_pntr_o), 1);
    @(posedge rd_clk_i); @(negedge rd_clk_i);
    chk("uf_clear", int'(underflow_o), 0);

    // full drain and wrap
    @(posedge rd_clk_i); #1 aclr_i = 1'b1; wr_bin = 0;
    @(posedge rd_clk_i); #1 aclr_i = 1'b0; wr_bin = 8;
    repeat (3) @(posedge rd_clk_i);
    @(negedge rd_clk_i);
    chk("full_usedw", int'(rd_usedw_o), USEDW ? 8 : 0);
    chk("full_empty", int'(rd_empty_o), 0);
    @(posedge rd_clk_i); #1 rd_req_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge rd_clk_i);
      chk("drain_strobe", int'(ram_rd_req_o), (i < 8) ? 1 : 0);
      chk("drain_addr",   int'(rd_pntr_o), i % 8);
      @(posedge rd_clk_i); #1;
    end
    rd_req_i = 1'b0;
    @(negedge rd_clk_i);
    chk("drain_gray",  int'(rd_pntr_gray_o), 4'b1100);
    chk("drain_empty", int'(rd_empty_o), 1);
    chk("drain_uf",    int'(underflow_o), 1);

    // reset mid-stream with address 5
    @(posedge rd_clk_i); #1 wr_bin = 14;
    repeat (3) @(posedge rd_clk_i);
    #1 rd_req_i = 1'b1;
    repeat (5) @(posedge rd_clk_i);
    #1 chk("mid_addr_pre", int'(rd_pntr_o), 5);
    #2 aclr_i = 1'b1; wr_bin = 0;
    #1;
    chk("mid_addr",   int'(rd_pntr_o), 0);
    chk("mid_gray",   int'(rd_pntr_gray_o), 0);
    chk("mid_empty",  int'(rd_empty_o), 1);
    chk("mid_usedw",  int'(rd_usedw_o), 0);
    chk("mid_strobe", int'(ram_rd_req_o), 0);
    @(posedge rd_clk_i); #1 aclr_i = 1'b0; rd_req_i = 1'b0;

    // streaming: one write every 2 cycles, consumer reads whenever not empty
    strobes = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge rd_clk_i); #1;
      if (c % 2 == 0 && c < 40) wr_bin = (wr_bin + 1) % 16;
      rd_req_i = !rd_empty_o;
      @(negedge rd_clk_i);
      if (ram_rd_req_o) strobes++;
    end
    rd_req_i = 1'b0;
    chk("stream_strobes", strobes, 20);
    @(negedge rd_clk_i);
    chk("stream_addr",  int'(rd_pntr_o), 4);
    chk("stream_empty", int'(rd_empty_o), 1);

    repeat (2) @(posedge rd_clk_i);
    @(negedge rd_clk_i); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO. It sits in the `rd_clk_i` domain next to the FIFO storage RAM and owns the read pointer, the read address and read strobe, the empty flag and the fill count. It brings the Gray-coded write pointer across from the write domain and returns its own Gray-coded read pointer to the write-side controller.

## Interface
Parameters:
- `AWIDTH`, default 3: RAM address width. Depth is 2**AWIDTH. Internal pointers are AWIDTH+1 bits, with the extra MSB used as the wrap bit.
- `SYNC_STAGES`, default 2: number of flops in the write-pointer synchronizer. Legal values are 2 or more.

Ports:
- `rd_clk_i`, in, 1: read clock. Every register in the block runs on this clock.
- `aclr_i`, in, 1: reset. Asynchronous, active-high.
- `rd_req_i`, in, 1: consumer read request.
- `wr_pntr_gray_i`, in, AWIDTH+1: Gray write pointer from the write domain. It changes by at most one bit per write clock.
- `rd_pntr_o`, out, AWIDTH: RAM read address. This is the binary read pointer without its MSB.
- `ram_rd_req_o`, out, 1: RAM read strobe.
- `rd_empty_o`, out, 1: FIFO empty flag.
- `rd_usedw_o`, out, AWIDTH+1: words available to read, range 0..2**AWIDTH.
- `rd_pntr_gray_o`, out, AWIDTH+1: registered Gray read pointer sent to the write domain.
- `underflow_o`, out, 1: one-cycle pulse when a read is requested while the FIFO is empty.

## Operation
- Read acceptance: `rd_ack = rd_req_i && !rd_empty_o`. This is combinational.
  - `ram_rd_req_o = rd_ack`.
  - The RAM samples `rd_pntr_o` on the same edge.
  - Read data appears on the RAM output one cycle later.
- Pointer update:
  - Next binary pointer `rd_bin_next = rd_bin + rd_ack`, modulo 2**(AWIDTH+1).
  - `rd_gray_next = bin2gray(rd_bin_next)`.
  - Both are registered every edge.
- Write-pointer synchronizer: `wr_pntr_gray_i` passes through SYNC_STAGES flops. The last stage gives `wr_gray_s`. No logic is allowed between the synchronizer stages.
- Empty flag: the register `rd_empty_o <= (rd_gray_next == wr_gray_s)`.
  - The flag is pessimistic. It may stay asserted after data has been written, but it never deasserts while the FIFO is truly empty.
- Underflow: the register `underflow_o <= rd_req_i && rd_empty_o`.
  - The pointer does not move on an underflow.
  - The RAM is not strobed on an underflow.
- Fill count: the register `rd_usedw_o <= gray2bin(wr_gray_s) - rd_bin_next`, modulo 2**(AWIDTH+1).
- Wrap-around: the pointer wraps from 2**(AWIDTH+1)-1 to 0. Address bits wrap every 2**AWIDTH reads. The FIFO is full-as-seen-from-read when the count is 2**AWIDTH.
- Simultaneous read and write-pointer change in the same cycle: both are applied. The flags are computed from `rd_bin_next` and the current `wr_gray_s`.
- Reset, asynchronous and allowed at any time (including mid-transfer) with immediate effect:
  - `rd_pntr_o` = 0 and `rd_pntr_gray_o` = 0.
  - All synchronizer flops = 0.
  - `rd_empty_o` = 1, `rd_usedw_o` = 0, `underflow_o` = 0.
  - `ram_rd_req_o` = 0, because empty is asserted.

## Timing
- Read to address advance: 1 cycle. `rd_pntr_o` and `rd_pntr_gray_o` update on the edge that accepts the read.
- Read to empty/usedw: 1 cycle. A read of the last word sets `rd_empty_o` on the accepting edge, so no back-to-back over-read is possible.
- Write pointer to visible: SYNC_STAGES+1 `rd_clk_i` edges after `wr_pntr_gray_i` is stable.
- Throughput: one read per cycle while `rd_empty_o` = 0.

## Configuration
- `FIFO_RD_USEDW_EN` defined:
  - The gray2bin conversion, the subtractor and the `rd_usedw_o` register are built.
- `FIFO_RD_USEDW_EN` undefined:
  - `rd_usedw_o` is tied to 0.
  - Empty still uses the Gray compare only.
  - All other behaviour is identical.

## Structure
- Package `fifo_pkg`: `bin2gray` and `gray2bin` functions, parameterised by width.
- Sub-module `gray_sync`: a SYNC_STAGES-deep, width-parameterised synchronizer with async clear. The write-side controller reuses it.

## Test plan
All scenarios use AWIDTH=3 and SYNC_STAGES=2.
- Reset: assert `aclr_i` mid-stream with `rd_pntr_o` = 5 → immediately `rd_pntr_o` = 0, `rd_pntr_gray_o` = 0, `rd_empty_o` = 1, `rd_usedw_o` = 0, `ram_rd_req_o` = 0.
- Write-pointer crossing: from reset, `wr_pntr_gray_i` goes 0000→0001 → `rd_empty_o` falls and `rd_usedw_o` = 1 on the 3rd `rd_clk_i` edge.
- Single read: one word available, `rd_req_i` held for 1 cycle → `ram_rd_req_o` = 1 with `rd_pntr_o` = 0. Next edge: `rd_pntr_o` = 1, `rd_pntr_gray_o` = 0001, `rd_empty_o` = 1, `rd_usedw_o` = 0.
- Underflow: `rd_req_i` = 1 while empty → `ram_rd_req_o` = 0, pointer unchanged, `underflow_o` = 1 for exactly 1 cycle.
- Full drain and wrap: `wr_pntr_gray_i` = 1100 (binary 8), then `rd_usedw_o` = 8. Apply 8 consecutive reads:
  - `rd_pntr_o` sequence is 0..7, then 0.
  - `rd_pntr_gray_o` ends at 1100.
  - `rd_empty_o` sets on the 8th accepting edge, with no 9th strobe.
- Streaming: the write pointer advances one step every 2 `rd_clk_i` cycles and `rd_req_i` is held high → no underflow strobe and no over-read. Returned addresses are strictly sequential modulo 8.
